gmii_rx_filter_adp: RTL and testbench
=====================================

GMII_RX_FILTER_ADP -- requirements
Module: gmii_rx_filter_adp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LATENCY, 10, input-to-output delay in cycles; legal range 9..32.
- MAX_LEN, 1522, maximum post-SFD bytes forwarded; legal range 64..16383.
- PRE_MIN, 7, minimum 0x55 preamble bytes before SFD; legal range 1..7.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_gmii_rxclk, in, 1, sole clock; all logic is on its rising edge.
- i_gmii_rst_n, in, 1, asynchronous active-low reset.
- i_port_type, in, 1, 1 = filter/truncate mode, 0 = pure delay mode.
- i_gmii_dv, in, 1, PHY-side receive data valid.
- i_gmii_er, in, 1, PHY-side receive error.
- iv_gmii_rxd, in, 8, PHY-side receive data.
- o_gmii_dv_adp2tsnchip, out, 1, valid toward the switch core.
- o_gmii_er_adp2tsnchip, out, 1, error toward the switch core.
- ov_gmii_rxd_adp2tsnchip, out, 8, data toward the switch core.
- ov_frame_cnt, out, 16, count of forwarded frames.
- ov_drop_cnt, out, 16, count of dropped frames.
- ov_trunc_cnt, out, 16, count of truncated frames.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 A frame SHALL be a maximal run of cycles with i_gmii_dv=1; the first such cycle is SOF.
REQ-005 The output SHALL be the input (dv, er, rxd) delayed by exactly LATENCY cycles through a registered delay line, subject to the gating in REQ-010 and REQ-011.
REQ-006 Each delay slot SHALL carry dv, er, rxd and an SOF flag.
REQ-007 The input FSM SHALL have the states IDLE, PRE, DATA and DROP. i_port_type SHALL be sampled at SOF and held for the rest of the frame.
REQ-008 FSM transitions in filter mode SHALL be:
- IDLE, SOF with 0x55: go to PRE, set pre_cnt=1.
- IDLE, SOF with any other byte: go to DROP.
- PRE, dv=0: go to IDLE and drop the frame.
- PRE, 0x55 while pre_cnt<7: increment pre_cnt.
- PRE, 0x55 while pre_cnt=7: go to DROP.
- PRE, 0xD5 while pre_cnt>=PRE_MIN: go to DATA, set len=0, keep the frame.
- PRE, any other byte: go to DROP.
- DATA, dv=1: increment len (11-bit... 14-bit counter, no wrap past MAX_LEN).
- DATA or DROP, dv=0: go to IDLE.
REQ-009 Exactly one keep/drop decision per frame SHALL be pushed into a 16-entry decision FIFO at the moment the decision is made. LATENCY>=9 guarantees the decision is pushed no later than its SOF slot reaching the output; the FIFO never overflows.
REQ-010 When an SOF slot reaches the output, the block SHALL pop one decision. If the decision is drop, it SHALL force dv=0, er=0 and rxd=0 for that slot and for every following slot until the next SOF.
REQ-011 Truncation (filter mode): the post-SFD byte with len=MAX_LEN SHALL be forwarded with er=1. All later bytes of that frame SHALL enter the delay line with dv=0; the FSM SHALL then go to DROP with no further push.
REQ-012 In delay mode every frame SHALL be kept and none truncated; the FSM SHALL still track frame boundaries.
REQ-013 Input er SHALL pass through unchanged on kept bytes; OR it with the truncation er of REQ-011.
REQ-014 Kept frames SHALL be forwarded byte-exact, including preamble and SFD.
REQ-015 A frame starting on the cycle after the previous frame ends (gap of 1) SHALL be handled independently.

Reset
REQ-016 Reset SHALL clear every output, all counters, the delay line, the decision FIFO pointers and pre_cnt/len, and SHALL set the FSM to DROP.
REQ-017 If i_gmii_dv=1 when reset deasserts, that partial frame SHALL be discarded: it has no SOF, so nothing is pushed and DROP exits on dv=0. A dv=0 cycle SHALL return the FSM to IDLE.

Configuration
REQ-018 Macro GMII_ADP_STAT_EN SHALL control the statistics counters.
- Defined: ov_frame_cnt, ov_drop_cnt and ov_trunc_cnt each increment by 1 per keep push, drop push and truncation respectively, and wrap at 16'hFFFF->0.
- Undefined: the counters SHALL NOT be synthesised and the three outputs SHALL be tied to 0.

Verification
REQ-019 Filter mode, 7x0x55 + 0xD5 + 60 bytes: output identical to input 10 cycles later; frame_cnt=1.
REQ-020 Filter mode, PRE_MIN=7, 5x0x55 + 0xD5 + 60 bytes: output dv stays 0 for the whole frame; drop_cnt=1.
REQ-021 Filter mode, MAX_LEN=64, 8 preamble/SFD bytes + 100 bytes: 72 output dv cycles, er=1 on the 72nd only; trunc_cnt=1.
REQ-022 Back-to-back frames with a 1-cycle gap, bad then good: first fully suppressed, second intact, no byte lost or merged.
REQ-023 Delay mode, frame with 9x0x55 and no SFD: forwarded unchanged at LATENCY; drop_cnt=0.
REQ-024 Reset asserted mid-frame and released with dv=1: outputs 0 immediately; the partial frame is never output; the next frame passes normally.

Source files
------------

// File: rtl/gmii_rx_filter_adp_if.sv
// GMII receive bundle for gmii_rx_filter_adp: PHY-side inputs plus switch-core outputs and statistics.
// master drives the PHY side (source/bench); slave is the filter itself.
interface gmii_rx_filter_adp_if;
  logic        i_port_type;
  logic        i_gmii_dv;
  logic        i_gmii_er;
  logic [7:0]  iv_gmii_rxd;
  logic        o_gmii_dv_adp2tsnchip;
  logic        o_gmii_er_adp2tsnchip;
  logic [7:0]  ov_gmii_rxd_adp2tsnchip;
  logic [15:0] ov_frame_cnt;
  logic [15:0] ov_drop_cnt;
  logic [15:0] ov_trunc_cnt;

  modport master (
    output i_port_type, i_gmii_dv, i_gmii_er, iv_gmii_rxd,
    input  o_gmii_dv_adp2tsnchip, o_gmii_er_adp2tsnchip, ov_gmii_rxd_adp2tsnchip,
    input  ov_frame_cnt, ov_drop_cnt, ov_trunc_cnt
  );

  modport slave (
    input  i_port_type, i_gmii_dv, i_gmii_er, iv_gmii_rxd,
    output o_gmii_dv_adp2tsnchip, o_gmii_er_adp2tsnchip, ov_gmii_rxd_adp2tsnchip,
    output ov_frame_cnt, ov_drop_cnt, ov_trunc_cnt
  );
endinterface

// File: rtl/gmii_rx_filter_adp.sv
// GMII receive filter: delays the PHY stream by LATENCY cycles, dropping bad-preamble frames and truncating long ones.
// Statistics counters exist only when GMII_ADP_STAT_EN is defined; otherwise the count outputs are tied to zero.
module gmii_rx_filter_adp #(
  parameter int LATENCY = 10,
  parameter int MAX_LEN = 1522,
  parameter int PRE_MIN = 7
) (
  input logic                 i_gmii_rxclk,
  input logic                 i_gmii_rst_n,
  gmii_rx_filter_adp_if.slave gmii
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  typedef struct packed {
    logic       sof;
    logic       dv;
    logic       er;
    logic [7:0] rxd;
  } slot_t;

  localparam int          SLOTS     = LATENCY - 1;
  localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);
  localparam logic [2:0]  PRE_MIN_W = 3'(PRE_MIN);

  state_t      state;
  logic        filter_q;
  logic [2:0]  pre_cnt;
  logic [13:0] len;
  logic [13:0] len_next;
  logic        sof;
  logic        trunc_now;
  logic        push;
  logic        push_keep;

  logic [15:0] dec_mem;
  logic [4:0]  wr_ptr;
  logic [4:0]  rd_ptr;
  logic        fifo_empty;
  logic        drop_active;
  logic        drop_now;

  slot_t       slots [SLOTS];
  slot_t       slot_in;
  slot_t       slot_out;

  logic        dv_q;
  logic        er_q;
  logic [7:0]  rxd_q;

  // IDLE is only ever left on dv=1 and re-entered on dv=0, so IDLE with dv=1 is exactly a start of frame.
  always_comb begin
    sof         = (state == IDLE) && gmii.i_gmii_dv;
    len_next    = len + 14'd1;
    trunc_now   = (state == DATA) && gmii.i_gmii_dv && filter_q && (len_next == MAX_LEN_W);
    slot_in.sof = sof;
    slot_in.dv  = gmii.i_gmii_dv && (state != DROP);
    slot_in.er  = gmii.i_gmii_er || trunc_now;
    slot_in.rxd = gmii.iv_gmii_rxd;
  end

  always_comb begin
    push      = 1'b0;
    push_keep = 1'b0;
    case (state)
      IDLE: begin
        if (gmii.i_gmii_dv) begin
          if (!gmii.i_port_type) begin
            push      = 1'b1;
            push_keep = 1'b1;
          end else if (gmii.iv_gmii_rxd != 8'h55) begin
            push = 1'b1;
          end
        end
      end
      PRE: begin
        if (!gmii.i_gmii_dv) begin
          push = 1'b1;
        end else if (gmii.iv_gmii_rxd == 8'h55) begin
          push = (pre_cnt == 3'd7);
        end else begin
          push      = 1'b1;
          push_keep = (gmii.iv_gmii_rxd == 8'hD5) && (pre_cnt >= PRE_MIN_W);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_gmii_rxclk or negedge i_gmii_rst_n) begin
    if (!i_gmii_rst_n) begin
      state    <= DROP;
      filter_q <= 1'b0;
      pre_cnt  <= 3'd0;
      len      <= 14'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gmii.i_gmii_dv) begin
            filter_q <= gmii.i_port_type;
            len      <= 14'd0;
            if (!gmii.i_port_type) begin
              state <= DATA;
            end else if (gmii.iv_gmii_rxd == 8'h55) begin
              state   <= PRE;
              pre_cnt <= 3'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!gmii.i_gmii_dv) begin
            state <= IDLE;
          end else if (gmii.iv_gmii_rxd == 8'h55) begin
            if (pre_cnt == 3'd7) state <= DROP;
            else                 pre_cnt <= pre_cnt + 3'd1;
          end else if (push_keep) begin
            state <= DATA;
            len   <= 14'd0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!gmii.i_gmii_dv) begin
            state <= IDLE;
          end else if (trunc_now) begin
            state <= DROP;
            len   <= len_next;
          end else if (len != MAX_LEN_W) begin
            len <= len_next;
          end
        end
        default: begin
          if (!gmii.i_gmii_dv) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_gmii_rxclk or negedge i_gmii_rst_n) begin
    if (!i_gmii_rst_n) begin
      dec_mem <= '0;
      wr_ptr  <= 5'd0;
    end else if (push) begin
      dec_mem[wr_ptr[3:0]] <= push_keep;
      wr_ptr               <= wr_ptr + 5'd1;
    end
  end

  // A drop decision popped at an SOF slot keeps blanking every slot until the next SOF pops a new one.
  always_comb begin
    slot_out   = slots[SLOTS-1];
    fifo_empty = (wr_ptr == rd_ptr);
    drop_now   = slot_out.sof ? (fifo_empty || !dec_mem[rd_ptr[3:0]]) : drop_active;
  end

  always_ff @(posedge i_gmii_rxclk or negedge i_gmii_rst_n) begin
    if (!i_gmii_rst_n) begin
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
      rd_ptr      <= 5'd0;
      drop_active <= 1'b1;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      rxd_q       <= 8'd0;
    end else begin
      slots[0] <= slot_in;
      for (int i = 1; i < SLOTS; i++) slots[i] <= slots[i-1];
      if (slot_out.sof && !fifo_empty) rd_ptr <= rd_ptr + 5'd1;
      drop_active <= drop_now;
      dv_q        <= slot_out.dv && !drop_now;
      er_q        <= slot_out.er && !drop_now;
      rxd_q       <= drop_now ? 8'd0 : slot_out.rxd;
    end
  end

  assign gmii.o_gmii_dv_adp2tsnchip   = dv_q;
  assign gmii.o_gmii_er_adp2tsnchip   = er_q;
  assign gmii.ov_gmii_rxd_adp2tsnchip = rxd_q;

`ifdef GMII_ADP_STAT_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] trunc_cnt;

  always_ff @(posedge i_gmii_rxclk or negedge i_gmii_rst_n) begin
    if (!i_gmii_rst_n) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
      trunc_cnt <= 16'd0;
    end else begin
      if (push && push_keep)  frame_cnt <= frame_cnt + 16'd1;
      if (push && !push_keep) drop_cnt  <= drop_cnt + 16'd1;
      if (trunc_now)          trunc_cnt <= trunc_cnt + 16'd1;
    end
  end

  assign gmii.ov_frame_cnt = frame_cnt;
  assign gmii.ov_drop_cnt  = drop_cnt;
  assign gmii.ov_trunc_cnt = trunc_cnt;
`else
  assign gmii.ov_frame_cnt = 16'd0;
  assign gmii.ov_drop_cnt  = 16'd0;
  assign gmii.ov_trunc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_gmii_rx_filter_adp.sv
// Self-checking bench for gmii_rx_filter_adp: frame-level vector table, hand-written corner sequences,
// and random traffic compared against a frame-classifying reference model.
module tb_gmii_rx_filter_adp;

  localparam int LATENCY = 10;
  localparam int MAX_LEN = 64;
  localparam int PRE_MIN = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gmii_rx_filter_adp_if bus ();

  gmii_rx_filter_adp #(
    .LATENCY (LATENCY),
    .MAX_LEN (MAX_LEN),
    .PRE_MIN (PRE_MIN)
  ) dut (
    .i_gmii_rxclk (clk),
    .i_gmii_rst_n (rst_n),
    .gmii         (bus)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic       dv;
    logic       er;
    logic [7:0] rxd;
    logic       pt;
  } cyc_t;

  typedef struct {
    int         n_pre;
    bit         has_sfd;
    logic [7:0] sfd;
    int         n_pay;
    logic       pt;
    int         exp_dv;
    int         exp_er_at;
    bit         exp_keep;
    bit         exp_trunc;
  } vec_t;

  cyc_t       stim_q[$];
  logic [9:0] out_q[$];
  int         errors = 0;
  int         checks = 0;
  vec_t       vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic er, input logic [7:0] rxd, input logic pt);
    cyc_t c;
    bus.i_gmii_dv   = dv;
    bus.i_gmii_er   = er;
    bus.iv_gmii_rxd = rxd;
    bus.i_port_type = pt;
    c.dv = dv; c.er = er; c.rxd = rxd; c.pt = pt;
    stim_q.push_back(c);
    @(negedge clk);
    out_q.push_back({bus.o_gmii_dv_adp2tsnchip, bus.o_gmii_er_adp2tsnchip, bus.ov_gmii_rxd_adp2tsnchip});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_er(input int rate);
    return (rate != 0) && ($urandom_range(0, rate - 1) == 0);
  endfunction

  task automatic send_frame(input int n_pre, input bit has_sfd, input logic [7:0] sfd,
                            input int n_pay, input logic pt, input int er_rate);
    for (int i = 0; i < n_pre; i++) applyStimulus(1'b1, rnd_er(er_rate), 8'h55, pt);
    if (has_sfd) applyStimulus(1'b1, rnd_er(er_rate), sfd, pt);
    for (int i = 0; i < n_pay; i++) applyStimulus(1'b1, rnd_er(er_rate), 8'($urandom), pt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Reference: split the recorded input into frames, classify each by the preamble/SFD rules,
  // and build the expected output stream, which must appear LATENCY cycles later.
  task automatic run_model_and_compare(input string tag);
    int         n = stim_q.size();
    int         i = 0;
    bit         drop_cur = 1'b1;
    int         keeps = 0, drops = 0, truncs = 0;
    logic [9:0] exp_a[];
    logic [9:0] want;
    exp_a = new[n];
    while (i < n && stim_q[i].dv) begin
      exp_a[i] = 10'd0;
      i++;
    end
    while (i < n) begin
      if (!stim_q[i].dv) begin
        exp_a[i] = drop_cur ? 10'd0 : {1'b0, stim_q[i].er, stim_q[i].rxd};
        i++;
      end else begin
        int j = i;
        int k = 0;
        bit filt = stim_q[i].pt;
        bit keep;
        while (j < n && stim_q[j].dv) j++;
        while (k < 8 && i + k < j && stim_q[i+k].rxd == 8'h55) k++;
        keep = !filt || (k >= PRE_MIN && k <= 7 && i + k < j && stim_q[i+k].rxd == 8'hD5);
        drop_cur = !keep;
        if (keep) keeps++;
        else      drops++;
        if (keep && filt && (j - i - k - 1) >= MAX_LEN) truncs++;
        for (int m = i; m < j; m++) begin
          int post = m - (i + k);
          if (!keep)                        exp_a[m] = 10'd0;
          else if (filt && post > MAX_LEN)  exp_a[m] = {1'b0, stim_q[m].er, stim_q[m].rxd};
          else if (filt && post == MAX_LEN) exp_a[m] = {2'b11, stim_q[m].rxd};
          else                              exp_a[m] = {1'b1, stim_q[m].er, stim_q[m].rxd};
        end
        i = j;
      end
    end
    for (int c = 0; c < out_q.size(); c++) begin
      want = (c < LATENCY) ? 10'd0 : exp_a[c - LATENCY];
      checkOutput($sformatf("%s out[%0d]", tag, c), out_q[c], want);
    end
`ifdef GMII_ADP_STAT_EN
    checkOutput($sformatf("%s frame_cnt", tag), bus.ov_frame_cnt, keeps);
    checkOutput($sformatf("%s drop_cnt", tag), bus.ov_drop_cnt, drops);
    checkOutput($sformatf("%s trunc_cnt", tag), bus.ov_trunc_cnt, truncs);
`else
    checkOutput($sformatf("%s frame_cnt", tag), bus.ov_frame_cnt, 0);
    checkOutput($sformatf("%s drop_cnt", tag), bus.ov_drop_cnt, 0);
    checkOutput($sformatf("%s trunc_cnt", tag), bus.ov_trunc_cnt, 0);
    $display("[TB] %s model counts keep=%0d drop=%0d trunc=%0d", tag, keeps, drops, truncs);
`endif
    stim_q.delete();
    out_q.delete();
  endtask

  function automatic int count_dv(input int from);
    int cnt = 0;
    for (int c = from; c < out_q.size(); c++) if (out_q[c][9]) cnt++;
    return cnt;
  endfunction

  initial begin
    int s, sb, dv_cnt, er_cnt, er_at;
    logic [15:0] f0, d0, t0;

    vecs[0] = '{7, 1'b1, 8'hD5,  60, 1'b1,  68,  0, 1'b1, 1'b0};
    vecs[1] = '{5, 1'b1, 8'hD5,  60, 1'b1,   0,  0, 1'b0, 1'b0};
    vecs[2] = '{7, 1'b1, 8'hD5, 100, 1'b1,  72, 72, 1'b1, 1'b1};
    vecs[3] = '{9, 1'b0, 8'h00,   0, 1'b0,   9,  0, 1'b1, 1'b0};
    vecs[4] = '{7, 1'b1, 8'hD5,  64, 1'b1,  72, 72, 1'b1, 1'b1};
    vecs[5] = '{7, 1'b1, 8'hD5,  63, 1'b1,  71,  0, 1'b1, 1'b0};
    vecs[6] = '{8, 1'b1, 8'hD5,  10, 1'b1,   0,  0, 1'b0, 1'b0};
    vecs[7] = '{7, 1'b1, 8'hD4,  10, 1'b1,   0,  0, 1'b0, 1'b0};
    vecs[8] = '{7, 1'b1, 8'hD5, 100, 1'b0, 108,  0, 1'b1, 1'b0};
    vecs[9] = '{0, 1'b1, 8'hD5,  10, 1'b1,   0,  0, 1'b0, 1'b0};

    bus.i_port_type = 1'b0;
    bus.i_gmii_dv   = 1'b0;
    bus.i_gmii_er   = 1'b0;
    bus.iv_gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset dv/er/rxd",
                {bus.o_gmii_dv_adp2tsnchip, bus.o_gmii_er_adp2tsnchip, bus.ov_gmii_rxd_adp2tsnchip}, 0);
    checkOutput("reset counters", {bus.ov_frame_cnt, bus.ov_drop_cnt}, 0);
    checkOutput("reset trunc_cnt", bus.ov_trunc_cnt, 0);
    rst_n = 1'b1;
    idle(3);

    for (int v = 0; v < 10; v++) begin
      s  = stim_q.size();
      f0 = bus.ov_frame_cnt;
      d0 = bus.ov_drop_cnt;
      t0 = bus.ov_trunc_cnt;
      send_frame(vecs[v].n_pre, vecs[v].has_sfd, vecs[v].sfd, vecs[v].n_pay, vecs[v].pt, 0);
      idle(LATENCY + 3);
      dv_cnt = 0; er_cnt = 0; er_at = 0;
      for (int c = s + LATENCY; c < out_q.size(); c++) begin
        if (out_q[c][9]) begin
          dv_cnt++;
          if (out_q[c][8]) begin
            er_cnt++;
            if (er_at == 0) er_at = dv_cnt;
          end
        end
      end
      checkOutput($sformatf("vec%0d dv cycles", v), dv_cnt, vecs[v].exp_dv);
      checkOutput($sformatf("vec%0d er position", v), er_at, vecs[v].exp_er_at);
      checkOutput($sformatf("vec%0d er count", v), er_cnt, (vecs[v].exp_er_at != 0) ? 1 : 0);
`ifdef GMII_ADP_STAT_EN
      checkOutput($sformatf("vec%0d frame_cnt delta", v), 16'(bus.ov_frame_cnt - f0), vecs[v].exp_keep);
      checkOutput($sformatf("vec%0d drop_cnt delta", v), 16'(bus.ov_drop_cnt - d0), !vecs[v].exp_keep);
      checkOutput($sformatf("vec%0d trunc_cnt delta", v), 16'(bus.ov_trunc_cnt - t0), vecs[v].exp_trunc);
`else
      checkOutput($sformatf("vec%0d counters tied", v), {bus.ov_frame_cnt, bus.ov_drop_cnt, f0, d0, t0}, 0);
`endif
    end

    // Bad frame then good frame separated by a single idle cycle.
    s = stim_q.size();
    send_frame(3, 1'b1, 8'hD5, 20, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
    sb = stim_q.size();
    send_frame(7, 1'b1, 8'hD5, 30, 1'b1, 0);
    idle(LATENCY + 3);
    checkOutput("b2b dv cycles", count_dv(s + LATENCY), 38);
    checkOutput("b2b second sof", out_q[sb + LATENCY], {2'b10, 8'h55});
    checkOutput("b2b gap blanked", out_q[sb + LATENCY - 1], 0);
    checkOutput("b2b bad tail blanked", out_q[sb + LATENCY - 2], 0);

    for (int f = 0; f < 120; f++) begin
      logic pt = ($urandom_range(0, 3) != 0);
      int   n_pre = ($urandom_range(0, 3) != 0) ? 7 : int'($urandom_range(0, 9));
      bit   has_sfd = ($urandom_range(0, 9) != 0);
      logic [7:0] sfd = ($urandom_range(0, 7) != 0) ? 8'hD5 : 8'($urandom);
      send_frame(n_pre, has_sfd, sfd, $urandom_range(0, 90), pt, 32);
      repeat ($urandom_range(1, 4)) applyStimulus(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
    end
    idle(LATENCY + 3);
    run_model_and_compare("seg1");

    // Reset in the middle of a kept frame, released while dv is still high.
    send_frame(7, 1'b1, 8'hD5, 20, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset outputs",
                {bus.o_gmii_dv_adp2tsnchip, bus.o_gmii_er_adp2tsnchip, bus.ov_gmii_rxd_adp2tsnchip}, 0);
    checkOutput("mid-reset counters", {bus.ov_frame_cnt, bus.ov_drop_cnt, bus.ov_trunc_cnt}, 0);
    for (int i = 0; i < 2; i++) begin
      bus.i_gmii_dv   = 1'b1;
      bus.iv_gmii_rxd = 8'($urandom);
      @(posedge clk);
      #1;
    end
    stim_q.delete();
    out_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    send_frame(7, 1'b1, 8'hD5, 30, 1'b1, 0);
    idle(LATENCY + 3);
    checkOutput("post-reset dv cycles", count_dv(0), 38);
    run_model_and_compare("seg2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
